// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-back, write-allocate cache between the core's
// 32-bit memory port and a 256-bit line-wide physical memory port.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   mem_read/mem_write  core request strobes, held until mem_resp
//   mem_byte_enable     byte lanes for a core write
//   mem_address         core byte address ([1:0] ignored)
//   mem_wdata           core write data
//   mem_resp            one-cycle completion to the core
//   mem_rdata           read data, valid with mem_resp
//   pmem_read           line fill request
//   pmem_write          line writeback request
//   pmem_address        line-aligned physical address
//   pmem_wdata          victim line being written back
//   pmem_rdata          fill line from memory, valid with pmem_resp
//   pmem_resp           one-cycle completion from memory
module dm_cache #(
  parameter int S_OFFSET = 5,
  parameter int S_INDEX  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [3:0]                 mem_byte_enable,
  input  logic [31:0]                mem_address,
  input  logic [31:0]                mem_wdata,
  output logic                       mem_resp,
  output logic [31:0]                mem_rdata,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [31:0]                pmem_address,
  output logic [(8<<S_OFFSET)-1:0]   pmem_wdata,
  input  logic [(8<<S_OFFSET)-1:0]   pmem_rdata,
  input  logic                       pmem_resp
);

  localparam int LINE_W     = 8 << S_OFFSET;
  localparam int SETS       = 1 << S_INDEX;
  localparam int TAG_W      = 32 - S_OFFSET - S_INDEX;
  localparam int WORD_SEL_W = S_OFFSET - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  state_t state, state_next;

  logic [SETS-1:0]   valid_arr;
  logic [SETS-1:0]   dirty_arr;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [LINE_W-1:0] data_arr [SETS];

  logic [TAG_W-1:0]      req_tag;
  logic [S_INDEX-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  req;
  logic                  hit;
  logic [31:0]           cur_word;
  logic [31:0]           merged_word;

  // The miss address is captured when the miss is detected so the writeback
  // and fill complete consistently even if the core misbehaves and drops or
  // changes its request mid-miss.
  logic [TAG_W-1:0]   miss_tag;
  logic [S_INDEX-1:0] miss_index;

  logic write_hit;
  logic fill_done;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[1:0];

  assign req_tag   = mem_address[31 -: TAG_W];
  assign req_index = mem_address[S_OFFSET +: S_INDEX];
  assign req_word  = mem_address[2 +: WORD_SEL_W];
  assign req       = mem_read | mem_write;
  assign hit       = valid_arr[req_index] && (tag_arr[req_index] == req_tag);
  assign cur_word  = data_arr[req_index][32*req_word +: 32];

  // Byte-merge of the core write data into the currently stored word.
  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) begin
        merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Next-state and output decode. All outputs idle at zero, so an async reset
  // forcing the state to IDLE drops every strobe immediately. A request with
  // both strobes high takes the write path because write_hit only looks at
  // mem_write.
  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    write_hit    = 1'b0;
    fill_done    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            mem_rdata = cur_word;
            write_hit = mem_write;
          end else if (valid_arr[req_index] && dirty_arr[req_index]) begin
            state_next = WRITEBACK;
          end else begin
            state_next = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[miss_index], miss_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = data_arr[miss_index];
        if (pmem_resp) begin
          state_next = FILL;
        end
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, miss_index, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and per-set valid/dirty bits; these are the only reset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid_arr <= '0;
      dirty_arr <= '0;
    end else begin
      state <= state_next;
      if (fill_done) begin
        valid_arr[miss_index] <= 1'b1;
        dirty_arr[miss_index] <= 1'b0;
      end else if (write_hit) begin
        dirty_arr[req_index] <= 1'b1;
      end
    end
  end

  // Tag/data arrays and the captured miss address carry no reset: a cleared
  // valid bit already makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && !hit) begin
      miss_tag   <= req_tag;
      miss_index <= req_index;
    end
    if (fill_done) begin
      tag_arr[miss_index]  <= miss_tag;
      data_arr[miss_index] <= pmem_rdata;
    end else if (write_hit) begin
      data_arr[req_index][32*req_word +: 32] <= merged_word;
    end
  end

endmodule

// File: doc/dm_cache.md
# dm_cache

Direct-mapped, write-back, write-allocate cache placed directly downstream of the multicycle RV32I core's memory port. It accepts the core's 32-bit `mem_*` request/response handshake unchanged and services misses over a 256-bit line-wide `pmem_*` port to physical memory. Eight sets of 32-byte lines; hits complete in the request cycle, and misses write back a dirty victim before refilling.

## Interface
- `S_OFFSET`, default 5: log2 of line bytes. Fixed at 5, giving a 256-bit line.
- `S_INDEX`, default 3: log2 of set count. Fixed at 3, giving 8 sets and a tag of `[31:8]`.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read` in 1: core read request, held until `mem_resp`.
- `mem_write` in 1: core write request, held until `mem_resp`.
- `mem_byte_enable` in 4: byte lanes for a write.
- `mem_address` in 32: byte address; bits `[1:0]` are ignored.
- `mem_wdata` in 32: core write data.
- `mem_resp` out 1: one-cycle completion to the core.
- `mem_rdata` out 32: read data, valid while `mem_resp`=1.
- `pmem_read` out 1: line fill request.
- `pmem_write` out 1: line writeback request.
- `pmem_address` out 32: line address, with bits `[4:0]`=0.
- `pmem_wdata` out 256: victim line data.
- `pmem_rdata` in 256: fill data, valid while `pmem_resp`=1.
- `pmem_resp` in 1: one-cycle completion from memory.

## Operation
- **Address split:** tag=`[31:8]`, index=`[7:5]`, word offset=`[4:2]`.
- **Per-set storage:** valid bit, dirty bit, 24-bit tag, 256-bit data.
- **State machine:** IDLE, WRITEBACK, FILL.
- **IDLE:**
  - With no request: all outputs 0; `mem_rdata` is don't-care.
  - hit = valid && tag match on the addressed set (combinational).
  - Read hit: `mem_resp`=1; `mem_rdata`=data[index][32*offset +: 32].
  - Write hit: `mem_resp`=1. At the clock edge, each byte b with `mem_byte_enable[b]`=1 is written into the addressed word and dirty is set. Dirty is set even when byte_enable=0000.
  - Miss with valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to FILL.
- **WRITEBACK:**
  - `pmem_write`=1; `pmem_address`={stored tag, index, 5'b0}; `pmem_wdata`=victim line.
  - Stays in WRITEBACK until `pmem_resp`, then goes to FILL.
- **FILL:**
  - `pmem_read`=1; `pmem_address`={request tag, index, 5'b0}.
  - On `pmem_resp`: data←`pmem_rdata`, tag←request tag, valid=1, dirty=0; go to IDLE.
  - The request is then served as a hit in IDLE.
- **`mem_resp`:** never asserted outside IDLE.
- **`mem_read` and `mem_write` both high:** illegal; the cache treats it as a write.
- **`pmem_resp` in IDLE:** ignored.
- **Core drops its request mid-miss:** illegal; the cache completes the fill regardless and returns to IDLE.
- **Reset (asynchronous):**
  - State←IDLE; all valid and dirty bits cleared.
  - Tag and data arrays are not reset.
  - Outputs drop to 0 immediately, including mid-WRITEBACK or mid-FILL. An in-flight writeback is lost.

## Timing
- **Hit latency:** `mem_resp` is asserted in the same cycle the request is presented (combinational from request and arrays).
- **Clean miss:**
  - Cycle 0: IDLE detects the miss.
  - Cycle 1 onward: FILL.
  - Cycle k: `pmem_resp`.
  - Cycle k+1: IDLE hit, `mem_resp`=1.
- **Dirty miss:** WRITEBACK from cycle 1; FILL starts the cycle after the writeback `pmem_resp`.
- **`pmem_*` strobes:**
  - `pmem_read`/`pmem_write` and `pmem_address` are stable while waiting.
  - Strobes deassert the cycle after `pmem_resp`.
  - `pmem_read` and `pmem_write` are never high together.
- **Array writes:** all array updates take effect at the rising clock edge. A write hit followed by a read of the same word on the next cycle returns the new data.

## Test plan
- **Cold read miss then hit:** after `rst`, read 0x0000_0040.
  - Expect `pmem_read`=1, `pmem_address`=0x40, `pmem_write`=0.
  - Return a line whose word i=0x1000_000i.
  - Expect `mem_resp` one cycle after `pmem_resp`, with `mem_rdata`=0x1000_0000.
  - Then read 0x4C: `mem_resp` in the same cycle, `mem_rdata`=0x1000_0003, no `pmem` activity.
- **Write hit with partial byte enable:** write 0x44, wdata 0xDEADBEEF, be 4'b0011.
  - Expect `mem_resp` in the same cycle.
  - Read 0x44 returns 0x1000_BEEF.
- **Dirty conflict eviction:** read 0x140 (same index 2).
  - Expect `pmem_write` with address 0x40 and `pmem_wdata` word1=0x1000_BEEF.
  - After its resp, expect `pmem_read` with address 0x140, then `mem_resp`.
- **Clean conflict eviction:** read 0x40 again.
  - Expect no `pmem_write`.
  - Expect `pmem_read` 0x40 only, with `mem_rdata` equal to the word memory returns.
- **Memory stall:** hold `pmem_resp` low for 20 cycles during FILL.
  - `pmem_read` and `pmem_address` stay constant.
  - `mem_resp` stays 0 throughout.
- **Reset mid-fill:** assert `rst` asynchronously while in FILL.
  - `pmem_read` falls without waiting for a clock edge.
  - After release, a read of the previously cached 0x4C misses and issues `pmem_read` 0x40.
